// File: rtl/uart_pkg.sv
// Shared UART definitions: frame length, baud-count table, FSM states and frame formats.
// Used by both the TX and RX engines.
package uart_pkg;

  localparam int FRAME_BITS = 11;
  localparam int CNT_W      = 19;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } txState_e;

  // Indexed by {EIGHT, PEN}.
  typedef enum logic [1:0] {
    FMT_7N = 2'b00,
    FMT_7P = 2'b01,
    FMT_8N = 2'b10,
    FMT_8P = 2'b11
  } frameFmt_e;

  typedef struct packed {
    logic [7:0] data;
    logic       eight;
    logic       pen;
    logic       ohel;
    logic [3:0] baud;
  } txCfg_t;

  function automatic logic [CNT_W-1:0] baud_count(input logic [3:0] code);
    logic [CNT_W-1:0] bc;
    case (code)
      4'd0:    bc = 19'd333333;
      4'd1:    bc = 19'd83333;
      4'd2:    bc = 19'd41667;
      4'd3:    bc = 19'd20833;
      4'd4:    bc = 19'd10417;
      4'd5:    bc = 19'd5208;
      4'd6:    bc = 19'd2604;
      4'd7:    bc = 19'd1736;
      4'd8:    bc = 19'd868;
      4'd9:    bc = 19'd434;
      4'd10:   bc = 19'd217;
      default: bc = 19'd109;
    endcase
    return bc;
  endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Host-side bus of the UART TX engine: load strobe, byte, line configuration and status.
// With TX_BREAK_EN defined the bus also carries the break request.
interface uart_tx_engine_if;

  logic       write;
  logic [7:0] outPort;
  logic       eight;
  logic       pen;
  logic       ohel;
  logic [3:0] baud;
  logic       tx;
  logic       txRdy;

`ifdef TX_BREAK_EN
  logic       brk;

  modport master (output write, outPort, eight, pen, ohel, baud, brk, input tx, txRdy);
  modport slave  (input write, outPort, eight, pen, ohel, baud, brk, output tx, txRdy);
`else
  modport master (output write, outPort, eight, pen, ohel, baud, input tx, txRdy);
  modport slave  (input write, outPort, eight, pen, ohel, baud, output tx, txRdy);
`endif

endinterface

// File: rtl/uart_bit_timer.sv
// Bit-time generator: counts 0..bc while enabled and pulses btu on the terminal count.
// The counter is held at zero whenever en is low.
module uart_bit_timer
  import uart_pkg::*;
(
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             en_i,
  input  logic [CNT_W-1:0] bc_i,
  output logic             btu_o
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    btu_o   = en_i && (count_q == bc_i);
    count_d = count_q + CNT_W'(1);
    if (!en_i || btu_o) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: frames a host byte (start, 7/8 data LSB first, optional parity, stops)
// and shifts it out on tx. Optional feature macro: TX_BREAK_EN (idle break request).
module uart_tx_engine
  import uart_pkg::*;
(
  input logic               clk_i,
  input logic               reset_i,
  uart_tx_engine_if.slave   txBus
);

  txState_e              state_q, state_d;
  logic [FRAME_BITS-1:0] sr_q, sr_d, loadImage;
  logic [3:0]            bitCnt_q, bitCnt_d;
  txCfg_t                cfg_q, cfg_d;
  logic                  tx_q, tx_d;
  logic                  txRdy_q, txRdy_d;
  logic                  brk, accept, btu, timerEn, parity;
  logic [CNT_W-1:0]      bitCount;

`ifdef TX_BREAK_EN
  assign brk = txBus.brk;
`else
  assign brk = 1'b0;
`endif

  assign accept   = (state_q == IDLE) && txBus.write && txRdy_q && !brk;
  assign timerEn  = (state_q == SHIFT);
  assign bitCount = baud_count(cfg_q.baud);

  uart_bit_timer u_bitTimer (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .en_i    (timerEn),
    .bc_i    (bitCount),
    .btu_o   (btu)
  );

  // Unused frame slots are filled with 1 so short frames end in extra stop bits.
  always_comb begin
    parity    = (cfg_q.eight ? ^cfg_q.data : ^cfg_q.data[6:0]) ^ cfg_q.ohel;
    loadImage = '1;
    case (frameFmt_e'({cfg_q.eight, cfg_q.pen}))
      FMT_7N:  loadImage = {3'b111, cfg_q.data[6:0], 1'b0};
      FMT_7P:  loadImage = {2'b11, parity, cfg_q.data[6:0], 1'b0};
      FMT_8N:  loadImage = {2'b11, cfg_q.data, 1'b0};
      FMT_8P:  loadImage = {1'b1, parity, cfg_q.data, 1'b0};
      default: loadImage = '1;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    bitCnt_d = bitCnt_q;
    cfg_d    = cfg_q;
    txRdy_d  = (state_q == IDLE) && !brk;
    tx_d     = ((state_q == IDLE) && brk) ? 1'b0 : sr_q[0];
    case (state_q)
      IDLE: begin
        if (accept) begin
          cfg_d.data  = txBus.outPort;
          cfg_d.eight = txBus.eight;
          cfg_d.pen   = txBus.pen;
          cfg_d.ohel  = txBus.ohel;
          cfg_d.baud  = txBus.baud;
          state_d     = LOAD;
        end
      end
      LOAD: begin
        sr_d     = loadImage;
        bitCnt_d = '0;
        state_d  = SHIFT;
      end
      SHIFT: begin
        if (btu) begin
          sr_d = {1'b1, sr_q[FRAME_BITS-1:1]};
          if (bitCnt_q == 4'(FRAME_BITS - 1)) begin
            bitCnt_d = '0;
            state_d  = IDLE;
          end else begin
            bitCnt_d = bitCnt_q + 4'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      sr_q     <= '1;
      bitCnt_q <= '0;
      cfg_q    <= '0;
      tx_q     <= 1'b1;
      txRdy_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bitCnt_q <= bitCnt_d;
      cfg_q    <= cfg_d;
      tx_q     <= tx_d;
      txRdy_q  <= txRdy_d;
    end
  end

  assign txBus.tx    = tx_q;
  assign txBus.txRdy = txRdy_q;

endmodule

// File: tb/tb_uart_tx_engine.sv
// Self-checking bench for uart_tx_engine: directed and randomized frames against a
// frame-level reference model; covers the break feature when TX_BREAK_EN is defined.
module tb_uart_tx_engine;

  logic clk;
  logic reset;
  int   checkCount;
  int   passCount;
  bit   expBits[$];
  int   baudTable[16] = '{333333, 83333, 41667, 20833, 10417, 5208, 2604, 1736,
                          868, 434, 217, 109, 109, 109, 109, 109};

  uart_tx_engine_if txBus();

  uart_tx_engine dut (
    .clk_i   (clk),
    .reset_i (reset),
    .txBus   (txBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end else begin
      passCount++;
    end
  endtask

  // Expected serial frame: start, data LSB first, optional parity, then stop bits to 11 slots.
  task automatic buildFrame(input logic [7:0] data, input logic eight, input logic pen,
                            input logic ohel);
    int nData;
    int ones;
    nData = eight ? 8 : 7;
    ones  = 0;
    expBits.delete();
    expBits.push_back(1'b0);
    for (int i = 0; i < nData; i++) begin
      expBits.push_back(data[i]);
      ones += int'(data[i]);
    end
    if (pen) begin
      expBits.push_back(bit'((ones % 2) ^ int'(ohel)));
    end
    while (expBits.size() < 11) begin
      expBits.push_back(1'b1);
    end
  endtask

  // Sends one frame from idle and checks tx at both ends of every bit plus txRdy timing.
  task automatic applyStimulus(input logic [7:0] data, input logic eight, input logic pen,
                               input logic ohel, input logic [3:0] baud,
                               input bit midWrite, input bit doneWrite, input int frameNo);
    int bc;
    int bitLen;
    int lowEnd;
    int midCycle;
    int k;
    int ph;
    buildFrame(data, eight, pen, ohel);
    bc       = baudTable[baud];
    bitLen   = bc + 1;
    lowEnd   = 11 * bitLen + 1;
    midCycle = int'($urandom_range(lowEnd - 10, 3));
    txBus.write   = 1'b1;
    txBus.outPort = data;
    txBus.eight   = eight;
    txBus.pen     = pen;
    txBus.ohel    = ohel;
    txBus.baud    = baud;
    @(posedge clk); #1;
    txBus.write = 1'b0;
    checkOutput($sformatf("f%0d acceptRdy", frameNo), 32'(txBus.txRdy), 32'd1);
    for (int c = 1; c <= lowEnd + 3; c++) begin
      @(posedge clk); #1;
      if (midWrite && c == midCycle) begin
        txBus.write   = 1'b1;
        txBus.outPort = ~data;
        txBus.eight   = ~eight;
        txBus.pen     = ~pen;
        txBus.ohel    = ~ohel;
        txBus.baud    = 4'($urandom_range(15, 0));
      end else if (doneWrite && c == lowEnd - 1) begin
        txBus.write   = 1'b1;
        txBus.outPort = 8'($urandom);
      end else begin
        txBus.write = 1'b0;
      end
      if (c == 1) begin
        checkOutput($sformatf("f%0d rdyFall", frameNo), 32'(txBus.txRdy), 32'd0);
        checkOutput($sformatf("f%0d preStart", frameNo), 32'(txBus.tx), 32'd1);
      end
      if (c >= 2 && c <= lowEnd) begin
        k  = (c - 2) / bitLen;
        ph = (c - 2) % bitLen;
        if (ph == 0 || ph == bc) begin
          checkOutput($sformatf("f%0d bit%0d ph%0d", frameNo, k, ph),
                      32'(txBus.tx), 32'(expBits[k]));
        end
      end
      if (c == lowEnd) begin
        checkOutput($sformatf("f%0d rdyLastLow", frameNo), 32'(txBus.txRdy), 32'd0);
      end
      if (c == lowEnd + 1) begin
        checkOutput($sformatf("f%0d rdyRise", frameNo), 32'(txBus.txRdy), 32'd1);
      end
      if (c == lowEnd + 3) begin
        checkOutput($sformatf("f%0d idleTx", frameNo), 32'(txBus.tx), 32'd1);
        checkOutput($sformatf("f%0d idleRdy", frameNo), 32'(txBus.txRdy), 32'd1);
      end
    end
  endtask

  task automatic applyReset(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] rData;
    logic       rEight;
    logic       rPen;
    logic       rOhel;
    logic [3:0] rBaud;
    bit         sawLow;

    checkCount    = 0;
    passCount     = 0;
    txBus.write   = 1'b0;
    txBus.outPort = 8'h00;
    txBus.eight   = 1'b1;
    txBus.pen     = 1'b0;
    txBus.ohel    = 1'b0;
    txBus.baud    = 4'd11;
`ifdef TX_BREAK_EN
    txBus.brk     = 1'b0;
`endif

    applyReset(3);
    checkOutput("resetTx", 32'(txBus.tx), 32'd1);
    checkOutput("resetRdy", 32'(txBus.txRdy), 32'd1);
    sawLow = 1'b0;
    repeat (1000) begin
      @(posedge clk); #1;
      if (txBus.tx !== 1'b1) sawLow = 1'b1;
    end
    checkOutput("idleHold", 32'(sawLow), 32'd0);

    applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0, 4'd11, 1'b0, 1'b0, 0);
    applyStimulus(8'h03, 1'b1, 1'b1, 1'b0, 4'd11, 1'b0, 1'b0, 1);
    applyStimulus(8'h03, 1'b1, 1'b1, 1'b1, 4'd11, 1'b0, 1'b0, 2);
    applyStimulus(8'hFF, 1'b0, 1'b1, 1'b0, 4'd11, 1'b0, 1'b0, 3);
    applyStimulus(8'h55, 1'b1, 1'b0, 1'b0, 4'd11, 1'b1, 1'b1, 4);

    // Reset in the middle of a start bit must return the line to idle on the next edge.
    txBus.write   = 1'b1;
    txBus.outPort = 8'hAA;
    @(posedge clk); #1;
    txBus.write = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("midStartBit", 32'(txBus.tx), 32'd0);
    applyReset(1);
    checkOutput("midResetTx", 32'(txBus.tx), 32'd1);
    checkOutput("midResetRdy", 32'(txBus.txRdy), 32'd1);
    applyStimulus(8'h3C, 1'b1, 1'b1, 1'b1, 4'd12, 1'b0, 1'b0, 5);

    for (int f = 0; f < 12; f++) begin
      rData  = 8'($urandom);
      rEight = 1'($urandom);
      rPen   = 1'($urandom);
      rOhel  = 1'($urandom);
      rBaud  = 4'($urandom_range(15, 10));
      applyStimulus(rData, rEight, rPen, rOhel, rBaud, bit'($urandom_range(1, 0)),
                    bit'($urandom_range(1, 0)), 10 + f);
    end

`ifdef TX_BREAK_EN
    txBus.brk = 1'b1;
    @(posedge clk); #1;
    checkOutput("breakTx", 32'(txBus.tx), 32'd0);
    checkOutput("breakRdy", 32'(txBus.txRdy), 32'd0);
    txBus.write   = 1'b1;
    txBus.outPort = 8'h0F;
    @(posedge clk); #1;
    txBus.write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("breakHoldTx", 32'(txBus.tx), 32'd0);
    txBus.brk = 1'b0;
    @(posedge clk); #1;
    checkOutput("releaseTx", 32'(txBus.tx), 32'd1);
    checkOutput("releaseRdy", 32'(txBus.txRdy), 32'd1);
    sawLow = 1'b0;
    repeat (200) begin
      @(posedge clk); #1;
      if (txBus.tx !== 1'b1 || txBus.txRdy !== 1'b1) sawLow = 1'b1;
    end
    checkOutput("breakWriteIgnored", 32'(sawLow), 32'd0);
`endif

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
